// File: rtl/ripple_count_monitor_if.sv
// Bundle of the counter input, snapshot handshake and status outputs of
// ripple_count_monitor. EXT_W must match the EXT_W of the attached monitor.
interface ripple_count_monitor_if #(
    parameter int EXT_W = 16
);
    logic [3:0]       cnt_in;
    logic             snap_req;
    logic             out_ready;
    logic [3:0]       stable_cnt;
    logic [EXT_W-1:0] ext_count;
    logic             wrap_pulse;
    logic             err_skip;
    logic             snap_valid;
    logic [EXT_W-1:0] snap_data;
    logic             snap_overrun;

    modport master (
        output cnt_in, snap_req, out_ready,
        input  stable_cnt, ext_count, wrap_pulse, err_skip,
               snap_valid, snap_data, snap_overrun
    );

    modport slave (
        input  cnt_in, snap_req, out_ready,
        output stable_cnt, ext_count, wrap_pulse, err_skip,
               snap_valid, snap_data, snap_overrun
    );
endinterface

// File: rtl/ripple_count_monitor.sv
// Monitor for an asynchronous 4-bit ripple counter: synchronizes the raw bits,
// waits until a code has been seen STABLE_CYCLES times in a row before
// accepting it, extends the count to EXT_W bits, flags wraps and skipped codes,
// and offers a held valid/ready snapshot of the extended count.
module ripple_count_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int EXT_W         = 16
) (
    input logic                   clk,
    input logic                   reset,
    ripple_count_monitor_if.slave bus
);
    localparam int              RUN_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
    localparam int              CHAIN_W = SYNC_STAGES * 4;

    typedef enum logic {IDLE, HOLD} snap_state_t;

    // Run length of identical samples, including the current one; saturates.
    function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] run_cur);
        if (run_cur == RUN_MAX) begin
            return RUN_MAX;
        end
        return run_cur + RUN_W'(1);
    endfunction

    logic [CHAIN_W-1:0] sync_chain;
    logic [3:0]         s;
    logic [3:0]         cand;
    logic [RUN_W-1:0]   run;
    logic [RUN_W-1:0]   run_next;
    logic               accept;
    logic [3:0]         delta;

    logic [3:0]         stable_cnt;
    logic [EXT_W-1:0]   ext_count;
    logic               wrap_pulse;
    logic               err_skip;

    snap_state_t        state;
    logic               snap_valid;
    logic [EXT_W-1:0]   snap_data;
    logic               snap_overrun;

    assign s = sync_chain[CHAIN_W-1 -: 4];

    // Per-bit synchronizer chain; newest sample enters the low nibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[CHAIN_W-5:0], bus.cnt_in};
        end
    end

    // Acceptance decision: the run length after this sample reaching
    // STABLE_CYCLES is what gives the SYNC_STAGES+STABLE_CYCLES edge latency.
    always_comb begin
        run_next = RUN_W'(1);
        if (s == cand) begin
            run_next = run_sat_inc(run);
        end
        accept = (run_next == RUN_MAX) && (s != stable_cnt);
        delta  = s - stable_cnt;
    end

    // Stability filter state and the accepted-count / extended-count update.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand       <= '0;
            run        <= '0;
            stable_cnt <= '0;
            ext_count  <= '0;
            wrap_pulse <= 1'b0;
            err_skip   <= 1'b0;
        end else begin
            cand       <= s;
            run        <= run_next;
            wrap_pulse <= 1'b0;
            err_skip   <= 1'b0;
            if (accept) begin
                stable_cnt <= s;
                ext_count  <= ext_count + {{(EXT_W-4){1'b0}}, delta};
                wrap_pulse <= (s < stable_cnt);
                err_skip   <= (delta > 4'd1);
            end
        end
    end

    // Snapshot FSM: capture in IDLE, hold until out_ready, flag requests
    // that arrive while a snapshot is still held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            snap_valid   <= 1'b0;
            snap_data    <= '0;
            snap_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.snap_req) begin
                        snap_data  <= ext_count;
                        snap_valid <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.snap_req) begin
                        snap_overrun <= 1'b1;
                    end
                    if (snap_valid && bus.out_ready) begin
                        snap_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stable_cnt   = stable_cnt;
    assign bus.ext_count    = ext_count;
    assign bus.wrap_pulse   = wrap_pulse;
    assign bus.err_skip     = err_skip;
    assign bus.snap_valid   = snap_valid;
    assign bus.snap_data    = snap_data;
    assign bus.snap_overrun = snap_overrun;
endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor at default parameters.
module tb_ripple_count_monitor;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    int   wraps;
    int   errs;
    int   both;
    int   seen7;

    ripple_count_monitor_if #(.EXT_W(16)) bus ();

    ripple_count_monitor #(
        .SYNC_STAGES(2),
        .STABLE_CYCLES(2),
        .EXT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        bus.cnt_in   = 4'd0;
        bus.snap_req = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        wraps = 0;
        errs  = 0;
        both  = 0;
        seen7 = 0;
    endtask

    // Drive a counter value for n cycles and tally the pulses seen.
    task automatic step_hold(input logic [3:0] v, input int n);
        bus.cnt_in = v;
        repeat (n) begin
            tick();
            if (bus.wrap_pulse === 1'b1) wraps++;
            if (bus.err_skip === 1'b1) errs++;
            if (bus.wrap_pulse === 1'b1 && bus.err_skip === 1'b1) both++;
            if (bus.stable_cnt === 4'd7) seen7++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.cnt_in = 4'd0;
        bus.snap_req = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        total_cnt++;
        if ({bus.stable_cnt, bus.ext_count, bus.wrap_pulse, bus.err_skip} !== 22'd0)
            $display("FAIL reset_count actual=%h/%h/%b/%b required=0", bus.stable_cnt, bus.ext_count, bus.wrap_pulse, bus.err_skip);
        else pass_cnt++;
        total_cnt++;
        if ({bus.snap_valid, bus.snap_data, bus.snap_overrun} !== 18'd0)
            $display("FAIL reset_snap actual=%b/%h/%b required=0", bus.snap_valid, bus.snap_data, bus.snap_overrun);
        else pass_cnt++;
        reset = 1'b0;
        clear_counts();
        step_hold(4'd0, 8);
        total_cnt++;
        if (bus.stable_cnt !== 4'd0 || bus.ext_count !== 16'd0 || wraps != 0 || errs != 0)
            $display("FAIL idle_zero actual=%0d/%0d/%0d/%0d required=0/0/0/0", bus.stable_cnt, bus.ext_count, wraps, errs);
        else pass_cnt++;
    endtask

    task automatic test_first_step();
        clear_counts();
        step_hold(4'd1, 3);
        total_cnt++;
        if (bus.stable_cnt !== 4'd0)
            $display("FAIL latency_early actual=%0d required=0", bus.stable_cnt);
        else pass_cnt++;
        step_hold(4'd1, 1);
        total_cnt++;
        if (bus.stable_cnt !== 4'd1 || bus.ext_count !== 16'd1)
            $display("FAIL latency_4th actual=%0d/%0d required=1/1", bus.stable_cnt, bus.ext_count);
        else pass_cnt++;
        step_hold(4'd1, 4);
        total_cnt++;
        if (wraps != 0 || errs != 0)
            $display("FAIL first_no_pulse actual=%0d/%0d required=0/0", wraps, errs);
        else pass_cnt++;
    endtask

    task automatic test_full_wrap();
        apply_reset();
        clear_counts();
        for (int v = 1; v < 16; v++) step_hold(4'(v), 8);
        step_hold(4'd0, 8);
        total_cnt++;
        if (bus.ext_count !== 16'd16 || bus.stable_cnt !== 4'd0)
            $display("FAIL wrap_ext actual=%0d/%0d required=16/0", bus.ext_count, bus.stable_cnt);
        else pass_cnt++;
        total_cnt++;
        if (wraps != 1 || errs != 0)
            $display("FAIL wrap_pulses actual=%0d/%0d required=1/0", wraps, errs);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        apply_reset();
        for (int v = 1; v <= 3; v++) step_hold(4'(v), 8);
        clear_counts();
        step_hold(4'd7, 1);
        step_hold(4'd3, 8);
        total_cnt++;
        if (seen7 != 0 || bus.stable_cnt !== 4'd3 || bus.ext_count !== 16'd3)
            $display("FAIL glitch_reject actual=%0d/%0d/%0d required=0/3/3", seen7, bus.stable_cnt, bus.ext_count);
        else pass_cnt++;
        step_hold(4'd4, 8);
        total_cnt++;
        if (bus.ext_count !== 16'd4 || errs != 0 || wraps != 0)
            $display("FAIL glitch_then_step actual=%0d/%0d/%0d required=4/0/0", bus.ext_count, errs, wraps);
        else pass_cnt++;
    endtask

    task automatic test_jumps();
        apply_reset();
        for (int v = 1; v <= 5; v++) step_hold(4'(v), 8);
        clear_counts();
        step_hold(4'd9, 8);
        total_cnt++;
        if (bus.ext_count !== 16'd9 || errs != 1 || wraps != 0)
            $display("FAIL jump_5_9 actual=%0d/%0d/%0d required=9/1/0", bus.ext_count, errs, wraps);
        else pass_cnt++;
        for (int v = 10; v <= 14; v++) step_hold(4'(v), 8);
        clear_counts();
        step_hold(4'd2, 8);
        total_cnt++;
        if (bus.ext_count !== 16'd18 || errs != 1 || wraps != 1 || both != 1)
            $display("FAIL jump_14_2 actual=%0d/%0d/%0d/%0d required=18/1/1/1", bus.ext_count, errs, wraps, both);
        else pass_cnt++;
    endtask

    task automatic test_snapshot();
        apply_reset();
        step_hold(4'd15, 8);
        step_hold(4'd0, 8);
        step_hold(4'd15, 8);
        step_hold(4'd0, 8);
        for (int v = 1; v <= 3; v++) step_hold(4'(v), 8);
        total_cnt++;
        if (bus.ext_count !== 16'h0023)
            $display("FAIL snap_setup actual=%h required=0023", bus.ext_count);
        else pass_cnt++;
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        total_cnt++;
        if (bus.snap_valid !== 1'b1 || bus.snap_data !== 16'h0023)
            $display("FAIL snap_capture actual=%b/%h required=1/0023", bus.snap_valid, bus.snap_data);
        else pass_cnt++;
        bus.cnt_in = 4'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (bus.snap_valid !== 1'b1 || bus.snap_data !== 16'h0023)
                $display("FAIL snap_hold cycle=%0d actual=%b/%h required=1/0023", i, bus.snap_valid, bus.snap_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (bus.ext_count !== 16'h0024 || bus.snap_overrun !== 1'b0)
            $display("FAIL snap_ext_moves actual=%h/%b required=0024/0", bus.ext_count, bus.snap_overrun);
        else pass_cnt++;
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        total_cnt++;
        if (bus.snap_overrun !== 1'b1 || bus.snap_valid !== 1'b1 || bus.snap_data !== 16'h0023)
            $display("FAIL snap_overrun actual=%b/%b/%h required=1/1/0023", bus.snap_overrun, bus.snap_valid, bus.snap_data);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.snap_valid !== 1'b0 || bus.snap_overrun !== 1'b1)
            $display("FAIL snap_release actual=%b/%b required=0/1", bus.snap_valid, bus.snap_overrun);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bus.snap_req = 1'b1;
        tick();
        total_cnt++;
        if (bus.snap_valid !== 1'b1 || bus.snap_data !== 16'h0024)
            $display("FAIL b2b_first actual=%b/%h required=1/0024", bus.snap_valid, bus.snap_data);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        tick();
        total_cnt++;
        if (bus.snap_valid !== 1'b0)
            $display("FAIL b2b_transfer_ignores_req actual=%b required=0", bus.snap_valid);
        else pass_cnt++;
        bus.out_ready = 1'b0;
        tick();
        bus.snap_req = 1'b0;
        total_cnt++;
        if (bus.snap_valid !== 1'b1 || bus.snap_data !== 16'h0024)
            $display("FAIL b2b_second actual=%b/%h required=1/0024", bus.snap_valid, bus.snap_data);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total_cnt++;
        if (bus.snap_valid !== 1'b0)
            $display("FAIL b2b_second_release actual=%b required=0", bus.snap_valid);
        else pass_cnt++;
        bus.cnt_in = 4'd5;
        tick();
        tick();
        tick();
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        total_cnt++;
        if (bus.snap_data !== 16'h0024 || bus.ext_count !== 16'h0025 || bus.stable_cnt !== 4'd5)
            $display("FAIL snap_pre_update actual=%h/%h/%0d required=0024/0025/5", bus.snap_data, bus.ext_count, bus.stable_cnt);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        for (int k = 0; k < 15; k++) begin
            step_hold(4'd15, 8);
            step_hold(4'd0, 8);
        end
        step_hold(4'd15, 8);
        bus.snap_req = 1'b1;
        tick();
        tick();
        bus.snap_req = 1'b0;
        total_cnt++;
        if (bus.snap_valid !== 1'b1 || bus.snap_data !== 16'h00FF || bus.snap_overrun !== 1'b1)
            $display("FAIL hold_ff actual=%b/%h/%b required=1/00ff/1", bus.snap_valid, bus.snap_data, bus.snap_overrun);
        else pass_cnt++;
        reset = 1'b1;
        bus.cnt_in = 4'd0;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (bus.snap_valid !== 1'b0 || bus.ext_count !== 16'd0 || bus.snap_overrun !== 1'b0 ||
            bus.stable_cnt !== 4'd0 || bus.snap_data !== 16'd0)
            $display("FAIL reset_in_hold actual=%b/%h/%b/%0d/%h required=0/0000/0/0/0000",
                     bus.snap_valid, bus.ext_count, bus.snap_overrun, bus.stable_cnt, bus.snap_data);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        clear_counts();
        reset = 1'b1;
        bus.cnt_in = 4'd0;
        bus.snap_req = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_first_step();
        test_full_wrap();
        test_glitch();
        test_jumps();
        test_snapshot();
        test_back_to_back();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/ripple_count_monitor.md
Name: ripple_count_monitor

Overview:
- Downstream consumer of the 4-bit ripple counter output, clocked in the system clock domain.
- Brings the counter's asynchronous, possibly skewed bits into clk through a synchronizer and rejects transient ripple states with a stability filter.
- Extends the 4-bit count to EXT_W bits, flags wrap-around and skipped codes, and offers a valid/ready snapshot port to downstream logic.

Parameters:
- SYNC_STAGES, 2, number of flops in the cnt_in synchronizer chain (min 2).
- STABLE_CYCLES, 2, consecutive identical synchronized samples required before a code is accepted (min 1).
- EXT_W, 16, width of the extended count and snapshot data (min 5).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- cnt_in  input  4  raw ripple counter output; asynchronous to clk.
- snap_req  input  1  single-cycle request to capture ext_count.
- out_ready  input  1  downstream ready for the snapshot.
- stable_cnt  output  4  last accepted 4-bit code.
- ext_count  output  EXT_W  extended running count.
- wrap_pulse  output  1  one-cycle pulse when an accepted update crosses 15->0.
- err_skip  output  1  one-cycle pulse when an accepted update advances by more than 1.
- snap_valid  output  1  snapshot holding.
- snap_data  output  EXT_W  captured ext_count.
- snap_overrun  output  1  sticky; snap_req arrived while a snapshot was held.

Behaviour:
- Reset: drives all of the following to 0 on the next rising edge:
  - outputs: stable_cnt, ext_count, wrap_pulse, err_skip, snap_valid, snap_data, snap_overrun;
  - internal state: synchronizer flops, filter candidate and run counter;
  - FSM goes to IDLE.
- Reset has priority over every other event, including mid-snapshot; the held snapshot is dropped.
- Synchronizer: a plain SYNC_STAGES-deep flop chain per bit; its output is s.
- Filter:
  - Candidate register c and run counter r.
  - If s != c: c <= s, r <= 1.
  - Else: r saturates at STABLE_CYCLES.
  - Acceptance fires when r == STABLE_CYCLES, c == s and c != stable_cnt.
- Latency: cnt_in held constant after a change updates stable_cnt on the (SYNC_STAGES+STABLE_CYCLES)th rising edge; this is 4 edges at defaults.
  - Any change of s before acceptance restarts the filter.
  - A glitch shorter than STABLE_CYCLES synchronized cycles is never accepted.
- Accept update, all registered in the same edge:
  - stable_cnt <= c.
  - d = (c - stable_cnt) mod 16, range 1..15.
  - ext_count <= ext_count + d, mod 2^EXT_W; ext_count wraps silently.
  - wrap_pulse = 1 if c < stable_cnt (numeric), which includes 15->0.
  - err_skip = 1 if d > 1.
  - Both pulses are high for exactly one cycle, 0 otherwise.
- Snapshot FSM, states IDLE and HOLD:
  - IDLE, snap_req=1: snap_data <= ext_count value present in that cycle, i.e. pre-update if an accept fires on the same edge. snap_valid <= 1 and the FSM moves to HOLD.
  - HOLD: snap_data and snap_valid stay stable.
  - HOLD with snap_valid && out_ready: return to IDLE and snap_valid <= 0.
  - HOLD, snap_req=1: the request is ignored and snap_overrun <= 1, sticky until reset. This includes the cycle in which out_ready completes the transfer.
- Back-to-back transfers: a new snapshot is accepted no earlier than the cycle after the transfer, so throughput is at most 1 snapshot per 2 cycles.
- No combinational path from cnt_in or out_ready to any output.

Test Plan:
- Reset then hold cnt_in=0 -> all outputs 0. Step cnt_in to 1, held -> stable_cnt=1 and ext_count=1 on the 4th edge; no pulses.
- Step cnt_in 0..15 then 0, each held 8 cycles -> ext_count=16, exactly one wrap_pulse (at the 15->0 accept), err_skip never high.
- From 3, glitch cnt_in to 7 for 1 cycle then back to 3, then step to 4 -> the 7 is never accepted; ext_count +1, no err_skip.
- Jump cnt_in 5->9 -> ext_count +4, err_skip pulse 1 cycle. Then jump 14->2 -> ext_count +4, wrap_pulse and err_skip both pulse.
- snap_req with ext_count=0x0023 and out_ready=0 for 5 cycles -> snap_valid=1 and snap_data=0x0023 stable throughout. Second snap_req during the hold -> snap_overrun=1. Raise out_ready -> snap_valid=0 next cycle.
- Assert reset during HOLD with ext_count=0x00FF -> next edge: snap_valid=0, ext_count=0, snap_overrun=0, stable_cnt=0.
